// File: rtl/regfile_mp.sv
// Parametrised two-read/one-write register bank with optional write bypass, hardwired-zero
// register 0 and a one-entry-per-cycle clear sweep after reset or on request.
module regfile_mp #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned AW      = 4,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             busy,
  output logic             wr_ack
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam logic [AW:0] LastPtr = {1'b0, {AW{1'b1}}};

  typedef enum logic {StSweep, StIdle} state_e;

  state_e           state_q, state_d;
  logic [AW:0]      ptr_q, ptr_d;
  logic [WIDTH-1:0] regb [DEPTH];
  logic             wr_en;

  assign busy  = (state_q == StSweep);
  assign wr_en = (state_q == StIdle) && we3 && !(ZERO_R0 && (wa3 == '0));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StSweep: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LastPtr) state_d = StIdle;
      end
      StIdle: begin
        if (clr) begin
          state_d = StSweep;
          ptr_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StSweep;
      ptr_q   <= '0;
      wr_ack  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wr_ack  <= wr_en;
    end
  end

  // Array has no reset: its contents are zeroed only by the sweep.
  always_ff @(posedge clk) begin
    if (state_q == StSweep) begin
      regb[ptr_q[AW-1:0]] <= '0;
    end else if (wr_en) begin
      regb[wa3] <= wd3;
    end
  end

  always_comb begin
    rd1 = regb[ra1];
    if (busy) begin
      rd1 = '0;
    end else if (ZERO_R0 && (ra1 == '0)) begin
      rd1 = '0;
    end else if (BYPASS && wr_en && (ra1 == wa3)) begin
      rd1 = wd3;
    end
  end

  always_comb begin
    rd2 = regb[ra2];
    if (busy) begin
      rd2 = '0;
    end else if (ZERO_R0 && (ra2 == '0)) begin
      rd2 = '0;
    end else if (BYPASS && wr_en && (ra2 == wa3)) begin
      rd2 = wd3;
    end
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor of the 16x8 two-read/one-write register bank; width and depth are configurable.
- Adds an optional write-to-read bypass, a configurable hardwired-zero register and a sequential clear engine.
- The clear engine runs after reset or on request and zeroes one register per cycle, signalling busy meanwhile.
- Sits in the datapath between the decoder's register fields and the ALU operand muxes; replaces the fixed bank in wider variants of the core.

Parameters:
- WIDTH, 8: data width of each register in bits.
- AW, 4: address width; DEPTH = 2**AW registers.
- BYPASS, 1: 1 = read ports return wd3 when reading the address being written this cycle; 0 = read old contents.
- ZERO_R0, 1: 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is ordinary.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; starts a clear sweep.
- clr  in  1  synchronous clear request; starts a clear sweep when idle.
- we3  in  1  write enable.
- wa3  in  AW  write address.
- wd3  in  WIDTH  write data.
- ra1  in  AW  read address, port 1.
- ra2  in  AW  read address, port 2.
- rd1  out  WIDTH  read data, port 1 (combinational).
- rd2  out  WIDTH  read data, port 2 (combinational).
- busy  out  1  high while a clear sweep is in progress.
- wr_ack  out  1  registered; high one cycle after a write is accepted.

Behaviour:
- FSM states:
  - SWEEP: ptr counts 0..DEPTH-1; each rising edge writes 0 to regb[ptr] and increments ptr. When ptr==DEPTH-1, the edge writes the last entry and moves to IDLE.
  - IDLE: normal operation.
- Reset (async, any time, including mid-sweep or mid-write):
  - Immediately: state=SWEEP, ptr=0, busy=1, wr_ack=0.
  - Array contents are not touched asynchronously; they are zeroed by the sweep.
  - Sweep length: exactly DEPTH cycles after reset deasserts; busy falls on the edge that writes regb[DEPTH-1].
- clr:
  - In IDLE, clr=1 at an edge causes state=SWEEP, ptr=0, busy=1 on that edge.
  - That edge performs no clear write. A simultaneous we3 on that same edge is still honoured (IDLE rules apply).
  - clr while busy is ignored; the sweep is not restarted.
- Writes:
  - Accepted only when state==IDLE and we3=1 and not (ZERO_R0 && wa3==0).
  - An accepted write sets regb[wa3] <= wd3 at the edge and wr_ack=1 for the following cycle; otherwise wr_ack=0.
  - Writes during SWEEP are dropped: no array change, wr_ack=0.
- Reads (combinational):
  - busy=1: rd1=rd2=0.
  - ZERO_R0 && ra==0: rd=0.
  - BYPASS && we3 && write accepted-eligible && ra==wa3: rd=wd3.
  - Otherwise rd=regb[ra].
  - Both ports resolve independently; identical addresses give identical data.
- Width rules:
  - ptr is AW+1 bits internally so DEPTH terminates cleanly.
  - No arithmetic on data; wd3 is stored unmodified.
- Latency: read 0 cycles; write visible on the next cycle (same cycle with BYPASS=1).
- No X may propagate to rd1/rd2 after the first sweep completes, regardless of any initial-file contents.

Test Plan:
- Reset at t=0, release; count edges -> busy high for exactly 16 edges (AW=4); afterwards all 16 addresses read 0x00; wr_ack=0 throughout.
- IDLE, write wa3=5 wd3=0xA7 with ra1=5 on the same cycle:
  - BYPASS=1 -> rd1=0xA7 before the edge.
  - BYPASS=0 -> rd1=0x00 before the edge and 0xA7 after.
  - wr_ack=1 on the next cycle.
- ZERO_R0=1, write wa3=0 wd3=0xFF -> rd1 with ra1=0 stays 0x00, wr_ack=0. With ZERO_R0=0 the same write gives rd1=0xFF.
- Fill regs 1..15 with 0x10+i, assert clr one cycle:
  - busy=1 for 16 cycles; a we3 to reg 3 issued mid-sweep is dropped (wr_ack=0).
  - All regs read 0x00 afterwards.
  - A second clr pulse mid-sweep does not extend busy.
- Assert reset asynchronously between edges at sweep ptr=7 -> busy stays 1, ptr restarts at 0, sweep completes 16 edges after release.
- WIDTH=16, AW=5: write 0xBEEF to reg 31, read on both ports -> rd1=rd2=0xBEEF; the post-reset sweep lasts 32 cycles.
